// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_ctrl
//  Purpose  : Bit-serial adder. A single full-adder cell computes A+B+CIN
//             one bit per clock. The sequence is IDLE -> SHIFT (WIDTH cycles)
//             -> FINISH (one cycle, DONE pulse) -> IDLE.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     operand width in bits, legal range 2..32 (default 8)
//  Ports
//    CLOCK_50  in   1      system clock, rising edge
//    RESET_N   in   1      synchronous reset, active low
//    START     in   1      begin an addition (sampled only in IDLE)
//    A, B      in   WIDTH  operands, captured on the START edge
//    CIN       in   1      initial carry-in, captured on the START edge
//    BUSY      out  1      high while bits are being sequenced (SHIFT)
//    DONE      out  1      one-cycle pulse, result valid (FINISH)
//    SUM       out  WIDTH  registered result, held until the next result
//    COUT      out  1      registered final carry
//    OVF       out  1      signed overflow; present only when the
//                          SERIAL_ADDER_CTRL_OVF_EN macro is defined
// ============================================================================
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  ,
  output logic             OVF
`endif
);

  // Counter must be able to represent WIDTH itself.
  localparam int                 CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   C_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   C_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;

  logic               sum_bit_d;
  logic               carry_d;

  // The single full-adder cell, fed by the operand LSBs and the carry register.
  always_comb begin
    sum_bit_d = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  end

`ifdef SERIAL_ADDER_CTRL_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= CIN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          // The A register doubles as the partial-sum accumulator: each
          // consumed operand bit leaves at the LSB while the freshly computed
          // sum bit enters at the MSB, so after WIDTH shifts it is the result.
          a_q     <= {sum_bit_d, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + C_ONE;
          if (cnt_q == C_LAST) begin
            // Final bit: publish the result so SUM/COUT only ever change here.
            sum_q   <= {sum_bit_d, a_q[WIDTH-1:1]};
            cout_q  <= carry_d;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
            // carry_q is the carry into the MSB, carry_d the carry out of it.
            ovf_q   <= carry_q ^ carry_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end

        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign SUM  = sum_q;
  assign COUT = cout_q;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  assign OVF  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder_ctrl
//  Purpose  : Self-checking bench for serial_adder_ctrl (WIDTH=8), using a
//             table of directed vectors plus hand-written multi-cycle
//             sequences for held START, reset and reset-abort behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         CLOCK_50;
  logic         RESET_N;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CIN;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         COUT;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  logic         OVF;
`endif

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .START    (START),
    .A        (A),
    .B        (B),
    .CIN      (CIN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .SUM      (SUM),
    .COUT     (COUT)
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    ,
    .OVF      (OVF)
`endif
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // One complete operation from IDLE. While it runs, START is re-asserted
  // with different operands, which must neither restart nor alter the result.
  task automatic run_op(input vec_t v);
    A = v.a; B = v.b; CIN = v.cin; START = 1'b1;
    step();                                   // capture edge k
    chk("busy_after_start", 32'(BUSY), 32'd1);
    chk("done_after_start", 32'(DONE), 32'd0);
    A = 8'h55; B = 8'h55; CIN = 1'b1;         // START stays high
    for (int i = 1; i < W; i++) begin
      step();
      chk("busy_in_shift", 32'(BUSY), 32'd1);
      chk("done_in_shift", 32'(DONE), 32'd0);
      if (i == W / 2) begin
        chk("sum_held_in_shift", 32'(SUM), 32'(prev_sum));
        chk("cout_held_in_shift", 32'(COUT), 32'(prev_cout));
      end
    end
    step();                                   // edge k+W
    chk("done_pulse", 32'(DONE), 32'd1);
    chk("busy_in_finish", 32'(BUSY), 32'd0);
    chk("sum_result", 32'(SUM), 32'(v.sum));
    chk("cout_result", 32'(COUT), 32'(v.cout));
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    chk("ovf_result", 32'(OVF), 32'(v.ovf));
`endif
    START = 1'b0;
    step();                                   // edge k+W+1, back in IDLE
    chk("done_one_cycle", 32'(DONE), 32'd0);
    chk("busy_idle", 32'(BUSY), 32'd0);
    chk("sum_held_idle", 32'(SUM), 32'(v.sum));
    prev_sum  = v.sum;
    prev_cout = v.cout;
  endtask

  initial begin
    vec_t v;
    int   seen_done;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[8] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};

    // Reset, with START asserted to show reset has priority.
    RESET_N = 1'b0; START = 1'b1; A = 8'hA5; B = 8'h3C; CIN = 1'b1;
    repeat (3) step();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_sum", 32'(SUM), 32'd0);
    chk("rst_cout", 32'(COUT), 32'd0);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    chk("rst_ovf", 32'(OVF), 32'd0);
`endif
    START = 1'b0; RESET_N = 1'b1;
    step();
    chk("idle_no_start", 32'(BUSY), 32'd0);
    prev_sum = '0; prev_cout = 1'b0;

    // Table-driven operations.
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i]);
    end

    // START held high: second operation only accepted once back in IDLE.
    A = 8'hFF; B = 8'hFF; CIN = 1'b1; START = 1'b1;
    step();
    chk("held_busy_k", 32'(BUSY), 32'd1);
    A = 8'h01; B = 8'h01; CIN = 1'b0;
    for (int i = 1; i < W; i++) begin
      step();
      chk("held_no_done_early", 32'(DONE), 32'd0);
    end
    step();
    chk("held_done", 32'(DONE), 32'd1);
    chk("held_sum", 32'(SUM), 32'hFF);
    chk("held_cout", 32'(COUT), 32'd1);
    step();
    chk("held_not_in_finish", 32'(BUSY), 32'd0);
    chk("held_done_drop", 32'(DONE), 32'd0);
    step();
    chk("held_second_accept", 32'(BUSY), 32'd1);
    START = 1'b0;
    for (int i = 1; i < W; i++) step();
    step();
    chk("second_done", 32'(DONE), 32'd1);
    chk("second_sum", 32'(SUM), 32'h02);
    chk("second_cout", 32'(COUT), 32'd0);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    chk("second_ovf", 32'(OVF), 32'd0);
`endif
    step();

    // Reset on the 4th SHIFT cycle aborts with no DONE.
    A = 8'h0F; B = 8'h0F; CIN = 1'b0; START = 1'b1;
    step();                                   // edge k
    START = 1'b0;
    repeat (3) step();                        // edges k+1..k+3
    RESET_N = 1'b0;
    step();                                   // edge k+4
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_sum", 32'(SUM), 32'd0);
    chk("abort_cout", 32'(COUT), 32'd0);
    RESET_N = 1'b1;
    seen_done = 0;
    for (int i = 0; i < W + 4; i++) begin
      step();
      if (DONE !== 1'b0 || BUSY !== 1'b0) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    prev_sum = '0; prev_cout = 1'b0;
    v = '{8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0};
    run_op(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; the legal range is 2..32.
REQ-002 The block SHALL have port CLOCK_50, input, width 1: the single system clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port RESET_N, input, width 1: the reset, which is synchronous and active-low.
REQ-004 The block SHALL have port START, input, width 1: the request to begin an addition; it is sampled only in IDLE.
REQ-005 The block SHALL have port A, input, width WIDTH: operand A, captured on the START edge.
REQ-006 The block SHALL have port B, input, width WIDTH: operand B, captured on the START edge.
REQ-007 The block SHALL have port CIN, input, width 1: the initial carry-in, captured on the START edge.
REQ-008 The block SHALL have port BUSY, output, width 1: high while the addition is being sequenced.
REQ-009 The block SHALL have port DONE, output, width 1: a one-cycle pulse marking the result as valid.
REQ-010 The block SHALL have port SUM, output, width WIDTH: the registered result.
REQ-011 The block SHALL have port COUT, output, width 1: the registered final carry.

Function
REQ-012 The block SHALL compute A+B+CIN bit-serially with one full-adder cell: sum = a^b^c; carry = (a&b)|(c&(a^b)).
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and FINISH.
REQ-014 In IDLE with START=1, the block SHALL capture A, B and CIN into internal shift and carry registers, clear the bit counter and enter SHIFT.
REQ-015 Each SHIFT cycle SHALL add the LSBs of the A and B shift registers with the carry register, shift the sum bit into the SUM register MSB, shift A and B right by 1, load the carry register with the cell carry, and increment the bit counter.
REQ-016 After WIDTH SHIFT cycles the block SHALL enter FINISH, with SUM holding the full result LSB-aligned and COUT equal to the final carry.
REQ-017 FINISH SHALL last exactly one cycle with DONE=1 and SHALL then return to IDLE unconditionally.
REQ-018 Latency SHALL be fixed: with START sampled at edge k, BUSY=1 from edge k to edge k+WIDTH and DONE=1 from edge k+WIDTH to edge k+WIDTH+1.
REQ-019 BUSY SHALL be 1 only in SHIFT, and DONE SHALL be 1 only in FINISH.
REQ-020 START SHALL be ignored in SHIFT and FINISH: no queuing and no restart.
REQ-021 Changes on A, B or CIN after the capture edge SHALL have no effect on the current operation.
REQ-022 SUM and COUT SHALL hold their last result in IDLE until the next operation's final SHIFT edge overwrites them.
REQ-023 The bit counter SHALL be wide enough to hold WIDTH and SHALL not wrap within an operation.

Reset
REQ-024 With RESET_N=0 at a rising edge, the block SHALL go to IDLE and clear SUM, COUT, BUSY, DONE, the counter and all shift/carry registers, plus OVF when present.
REQ-025 Reset SHALL take priority over START and over any state transition.
REQ-026 Reset asserted in SHIFT or FINISH SHALL abort the operation with no DONE pulse; a START after reset release SHALL be accepted normally.

Configuration
REQ-027 Macro SERIAL_ADDER_CTRL_OVF_EN SHALL control the signed-overflow feature.
REQ-028 With SERIAL_ADDER_CTRL_OVF_EN defined, the block SHALL add port OVF, output, width 1, registered on the final SHIFT edge as (carry into MSB) XOR (carry out of MSB), valid with DONE and held like SUM.
REQ-029 With SERIAL_ADDER_CTRL_OVF_EN undefined, the OVF port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Scenario: WIDTH=8, A=0x0F, B=0x01, CIN=0, START at edge k -> DONE at edge k+8 for 1 cycle, SUM=0x10, COUT=0.
REQ-031 Scenario: A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1, OVF=0 (macro on).
REQ-032 Scenario: A=0x7F, B=0x01, CIN=0 -> SUM=0x80, COUT=0, OVF=1 (macro on); with the macro off, the result is unchanged and there is no OVF port.
REQ-033 Scenario: A=0xFF, B=0xFF, CIN=1 -> SUM=0xFF, COUT=1; back-to-back START held high -> the second operation is accepted only at the edge after FINISH (in IDLE).
REQ-034 Scenario: START with A=0x01, B=0x02, then START with A=0x55, B=0x55 and the inputs changed during SHIFT -> the second START is ignored and the result is SUM=0x03.
REQ-035 Scenario: RESET_N=0 on the 4th SHIFT cycle -> the next cycle shows BUSY=0, DONE=0, SUM=0x00, COUT=0, and no DONE pulse ever appears; a new START with A=0x02, B=0x03 -> SUM=0x05.
